// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) ();
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch/sequencing front end: fetches instruction words over a req/valid
// handshake, presents each word for decode, and selects the next PC
// (sequential, jump or PC-relative branch) from the control unit's outputs.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [3:0]          opcode_o,
  output logic                instr_valid_o,
  input  logic                stall_i,
  input  logic                jump_i,
  input  logic                beq_i,
  input  logic                bne_i,
  input  logic                zero_i,
  output logic [ADDR_W-1:0]   pc_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               req_q;
  logic               instr_valid_q;

  logic               branch_taken_d;
  logic [ADDR_W-1:0]  seq_pc_d;
  logic [ADDR_W-1:0]  branch_pc_d;
  logic [ADDR_W-1:0]  next_pc_d;

  // Next-PC selection: jump beats branch, branch beats sequential; arithmetic wraps.
  always_comb begin
    branch_taken_d = (beq_i & zero_i) | (bne_i & ~zero_i);
    seq_pc_d       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    branch_pc_d    = seq_pc_d + {{(ADDR_W-4){instr_q[3]}}, instr_q[3:0]};
    next_pc_d      = seq_pc_d;
    if (jump_i) begin
      next_pc_d = instr_q[ADDR_W-1:0];
    end else if (branch_taken_d) begin
      next_pc_d = branch_pc_d;
    end else begin
      next_pc_d = seq_pc_d;
    end
  end

  // Fetch/decode FSM with registered request, instruction and valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= {INSTR_W{1'b0}};
      req_q         <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem.imem_valid) begin
            instr_q       <= imem.imem_rdata;
            state_q       <= ST_DECODE;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        ST_DECODE: begin
          // A stalled decode holds pc and instr; any memory response is ignored.
          if (!stall_i) begin
            pc_q          <= next_pc_d;
            state_q       <= ST_FETCH;
            req_q         <= 1'b1;
            instr_valid_q <= 1'b0;
          end else begin
            state_q <= ST_DECODE;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          req_q         <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign opcode_o       = instr_q[15:12];
  assign instr_valid_o  = instr_valid_q;
  assign pc_o           = pc_q;

endmodule
